logic_reduce_unit: RTL and testbench

Parametrised, handshaked successor to the fixed 16-bit bitwise gates. It folds a burst of WIDTH-bit words into one result using a selectable bitwise operation (AND, OR, XOR, NAND-fold). It sits between a word producer (register file or ALU operand bus) and any consumer needing a multi-word mask or parity word. It also reports an N-way "any bit set" flag.

---
 rtl/logic_reduce_pkg.sv | 8 +
 rtl/logic_reduce_unit_op.sv | 13 +
 rtl/logic_reduce_unit.sv | 61 ++++++
 tb/tb_logic_reduce_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/logic_reduce_pkg.sv
// logic_reduce_pkg: op encodings and FSM state encoding shared by the reduce unit and its op unit; no ports
package logic_reduce_pkg;
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
endpackage

// File: rtl/logic_reduce_unit_op.sv
// logic_op_unit: combinational WIDTH-bit two-operand bitwise unit; ports: op selects AND/OR/XOR/NAND, a and b are the operands, y is the result
module logic_op_unit
  import logic_reduce_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = op == OP_AND ? a & b : op == OP_OR ? a | b : op == OP_XOR ? a ^ b : ~(a & b);
endmodule

// File: rtl/logic_reduce_unit.sv
// logic_reduce_unit: folds a handshaked burst of words with a bitwise op; ports: clk/reset, in_* word stream with op and last, out_* result with any/count/trunc flags
module logic_reduce_unit
  import logic_reduce_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MAX_WORDS = 8,
  localparam int CNT_W = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_any,
  output logic [CNT_W-1:0] out_count,
  output logic             out_trunc
);
  state_t state, state_nxt;
  logic [1:0] op_q;
  logic [WIDTH-1:0] acc, fold, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic any_q, trunc_q, take, close;
  logic_op_unit #(.WIDTH(WIDTH)) u_op (.op(op_q), .a(acc), .b(in_data), .y(fold));
  assign in_ready = state != HOLD;
  assign out_valid = state == HOLD;
  assign take = in_valid && in_ready;
  always_comb begin
    cnt_nxt = state == IDLE ? CNT_W'(1) : cnt + CNT_W'(1);
    acc_nxt = state == IDLE ? in_data : fold;
    close = in_last || cnt_nxt == CNT_W'(MAX_WORDS);
    state_nxt = state == HOLD ? (out_ready ? IDLE : HOLD) : take ? (close ? HOLD : ACCUM) : state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op_q <= OP_AND;
      acc <= '0;
      cnt <= '0;
      any_q <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        acc <= acc_nxt;
        any_q <= |acc_nxt;
        cnt <= cnt_nxt;
        trunc_q <= !in_last;
        if (state == IDLE) op_q <= in_op;
      end
    end
  end
  assign out_data = acc;
  assign out_any = any_q;
  assign out_count = cnt;
  assign out_trunc = trunc_q;
endmodule

// File: tb/tb_logic_reduce_unit.sv
// tb_logic_reduce_unit: directed self-checking bench for logic_reduce_unit at default parameters
module tb_logic_reduce_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] in_data = '0;
  logic [1:0] in_op = 2'b00;
  logic in_last = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [15:0] out_data;
  logic out_any;
  logic [3:0] out_count;
  logic out_trunc;
  int vectors = 0;
  int errors = 0;
  logic_reduce_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_op(in_op), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_any(out_any), .out_count(out_count), .out_trunc(out_trunc)
  );
  always #5 clk = ~clk;
  task automatic send(input logic [15:0] d, input logic [1:0] op, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_op = op;
    in_last = last;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout in_ready=%b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    #3;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    vectors++; if (out_data !== 16'h0000) begin errors++; $display("FAIL rst_out_data got %h want 0000", out_data); end
    vectors++; if (out_any !== 1'b0) begin errors++; $display("FAIL rst_out_any got %b want 0", out_any); end
    vectors++; if (out_count !== 4'd0) begin errors++; $display("FAIL rst_out_count got %0d want 0", out_count); end
    vectors++; if (out_trunc !== 1'b0) begin errors++; $display("FAIL rst_out_trunc got %b want 0", out_trunc); end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  task automatic test_or();
    send(16'h00FF, 2'b01, 1'b0);
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL or_mid_valid got %b want 0", out_valid); end
    send(16'hFF00, 2'b01, 1'b1);
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL or_valid got %b want 1", out_valid); end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL or_in_ready got %b want 0", in_ready); end
    vectors++; if (out_data !== 16'hFFFF) begin errors++; $display("FAIL or_data got %h want ffff", out_data); end
    vectors++; if (out_any !== 1'b1) begin errors++; $display("FAIL or_any got %b want 1", out_any); end
    vectors++; if (out_count !== 4'd2) begin errors++; $display("FAIL or_count got %0d want 2", out_count); end
    vectors++; if (out_trunc !== 1'b0) begin errors++; $display("FAIL or_trunc got %b want 0", out_trunc); end
    drain();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL or_drain_valid got %b want 0", out_valid); end
  endtask
  task automatic test_xor();
    send(16'hF0F0, 2'b10, 1'b0);
    send(16'h0F0F, 2'b00, 1'b0);
    send(16'hFF00, 2'b00, 1'b1);
    vectors++; if (out_data !== 16'h00FF) begin errors++; $display("FAIL xor_data got %h want 00ff", out_data); end
    vectors++; if (out_count !== 4'd3) begin errors++; $display("FAIL xor_count got %0d want 3", out_count); end
    drain();
  endtask
  task automatic test_nand_multi();
    send(16'hFF00, 2'b11, 1'b0);
    send(16'h0F0F, 2'b11, 1'b0);
    send(16'hFFFF, 2'b11, 1'b1);
    vectors++; if (out_data !== 16'h0F00) begin errors++; $display("FAIL nand3_data got %h want 0f00", out_data); end
    vectors++; if (out_count !== 4'd3) begin errors++; $display("FAIL nand3_count got %0d want 3", out_count); end
    drain();
  endtask
  task automatic test_trunc_hold();
    for (int i = 0; i < 8; i++) send(16'hFFFF, 2'b00, 1'b0);
    in_valid = 1'b1;
    in_data = 16'h00F0;
    in_op = 2'b01;
    in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc %0d got %b want 0", i, in_ready); end
      vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cyc %0d got %b want 1", i, out_valid); end
      vectors++; if (out_data !== 16'hFFFF) begin errors++; $display("FAIL hold_data cyc %0d got %h want ffff", i, out_data); end
      vectors++; if (out_count !== 4'd8) begin errors++; $display("FAIL hold_count cyc %0d got %0d want 8", i, out_count); end
      vectors++; if (out_trunc !== 1'b1) begin errors++; $display("FAIL hold_trunc cyc %0d got %b want 1", i, out_trunc); end
      vectors++; if (out_any !== 1'b1) begin errors++; $display("FAIL hold_any cyc %0d got %b want 1", i, out_any); end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_valid got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ninth_valid got %b want 1", out_valid); end
    vectors++; if (out_data !== 16'h00F0) begin errors++; $display("FAIL ninth_data got %h want 00f0", out_data); end
    vectors++; if (out_count !== 4'd1) begin errors++; $display("FAIL ninth_count got %0d want 1", out_count); end
    vectors++; if (out_trunc !== 1'b0) begin errors++; $display("FAIL ninth_trunc got %b want 0", out_trunc); end
    drain();
  endtask
  task automatic test_last_at_max();
    for (int i = 0; i < 8; i++) send(16'(1 << i), 2'b01, i == 7);
    vectors++; if (out_data !== 16'h00FF) begin errors++; $display("FAIL lastmax_data got %h want 00ff", out_data); end
    vectors++; if (out_count !== 4'd8) begin errors++; $display("FAIL lastmax_count got %0d want 8", out_count); end
    vectors++; if (out_trunc !== 1'b0) begin errors++; $display("FAIL lastmax_trunc got %b want 0", out_trunc); end
    drain();
  endtask
  task automatic test_single();
    send(16'h1234, 2'b11, 1'b1);
    vectors++; if (out_data !== 16'h1234) begin errors++; $display("FAIL single_nand_data got %h want 1234", out_data); end
    vectors++; if (out_count !== 4'd1) begin errors++; $display("FAIL single_nand_count got %0d want 1", out_count); end
    vectors++; if (out_any !== 1'b1) begin errors++; $display("FAIL single_nand_any got %b want 1", out_any); end
    drain();
    send(16'h0000, 2'b00, 1'b1);
    vectors++; if (out_any !== 1'b0) begin errors++; $display("FAIL single_and_any got %b want 0", out_any); end
    vectors++; if (out_data !== 16'h0000) begin errors++; $display("FAIL single_and_data got %h want 0000", out_data); end
    drain();
  endtask
  task automatic test_reset_mid();
    send(16'hAAAA, 2'b01, 1'b0);
    send(16'h5555, 2'b01, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    vectors++; if (out_count !== 4'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", out_count); end
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    send(16'h0001, 2'b01, 1'b1);
    vectors++; if (out_data !== 16'h0001) begin errors++; $display("FAIL postrst_data got %h want 0001", out_data); end
    vectors++; if (out_count !== 4'd1) begin errors++; $display("FAIL postrst_count got %0d want 1", out_count); end
    vectors++; if (out_trunc !== 1'b0) begin errors++; $display("FAIL postrst_trunc got %b want 0", out_trunc); end
    drain();
  endtask
  initial begin
    test_reset();
    test_or();
    test_xor();
    test_nand_multi();
    test_trunc_hold();
    test_last_at_max();
    test_single();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
